uart_transmitter: RTL and testbench

- Serial UART transmit stage that sits directly upstream of the UART Receiver on the APB-attached UART path.
- Accepts a parallel byte on a start strobe and shifts out one frame: start bit, data LSB first, optional even-parity bit, stop bit.
- Bit timing matches the Receiver: each bit is held CLKS_PER_BIT clocks, so the transmitter's serial output can be looped straight into the Receiver's `in`.

---
 rtl/uart_transmitter.sv | 117 +++++++++++
 tb/tb_uart_transmitter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART transmit stage: start bit, LSB-first data, optional even parity, stop bit.
// Each bit is held CLKS_PER_BIT clocks so the line can loop straight into the receiver.
//
// state  | meaning
// IDLE   | line at mark (1), waiting for txStart
// START  | driving the start bit (0)
// DATA   | shifting data out LSB first
// PARITY | driving even parity of the latched byte
// STOP   | driving the stop bit (1)
module uart_transmitter #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 txStart,
   input  logic [DATA_BITS-1:0] in,
   input  logic                 parity_en,
   output logic                 out,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [CW-1:0]        cyc_cnt;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shift_reg;
   logic [DATA_BITS-1:0] data_latched;
   logic                 parity_latched;
   logic                 done_nxt;
   logic                 bit_end;
   logic                 last_bit;

   assign bit_end  = (cyc_cnt == CW'(CLKS_PER_BIT - 1));
   assign last_bit = (bit_idx == BW'(DATA_BITS - 1));
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      out       = 1'b1;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (txStart) state_nxt = START;
         end
         START: begin
            out = 1'b0;
            if (bit_end) state_nxt = DATA;
         end
         DATA: begin
            out = shift_reg[0];
            if (bit_end && last_bit) state_nxt = parity_latched ? PARITY : STOP;
         end
         PARITY: begin
            out = ^data_latched;
            if (bit_end) state_nxt = STOP;
         end
         STOP: begin
            if (bit_end) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Input capture only happens in IDLE, so mid-frame changes on in/parity_en are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_cnt        <= '0;
         bit_idx        <= '0;
         shift_reg      <= '0;
         data_latched   <= '0;
         parity_latched <= 1'b0;
      end else if (state == IDLE) begin
         cyc_cnt <= '0;
         bit_idx <= '0;
         if (txStart) begin
            shift_reg      <= in;
            data_latched   <= in;
            parity_latched <= parity_en;
         end
      end else if (bit_end) begin
         cyc_cnt <= '0;
         if (state == DATA) begin
            shift_reg <= shift_reg >> 1;
            bit_idx   <= last_bit ? '0 : bit_idx + 1'b1;
         end
      end else begin
         cyc_cnt <= cyc_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: scoreboard of queued frames checked by a line-decoding receiver model,
// plus direct checks of busy/done timing, reset behaviour and back-to-back framing.
module tb_uart_transmitter;

   localparam int CPB = 16;

   typedef struct packed {
      logic       par;
      logic [7:0] data;
   } sb_item_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       txStart;
   logic [7:0] in;
   logic       parity_en;
   logic       out;
   logic       busy;
   logic       done;

   int         n_checks = 0;
   int         n_errors = 0;
   sb_item_t   sb[$];
   logic       mon_en = 1'b1;

   uart_transmitter #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .txStart   (txStart),
      .in        (in),
      .parity_en (parity_en),
      .out       (out),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Receiver model: samples mid-bit, pops the expected frame and compares.
   sb_item_t   mon_e;
   logic [7:0] mon_d;
   logic       mon_pb;
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && !out) begin
            repeat (CPB / 2) @(negedge clk);
            check("rx_start_bit", out, 1'b0);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               mon_d[i] = out;
            end
            check("rx_sb_nonempty", sb.size() > 0, 1);
            mon_e = (sb.size() > 0) ? sb.pop_front() : '0;
            if (mon_e.par) begin
               repeat (CPB) @(negedge clk);
               mon_pb = out;
               check("rx_parity_bit", mon_pb, ^mon_e.data);
               check("rx_parity_err", ^mon_d ^ mon_pb, 1'b0);
            end
            repeat (CPB) @(negedge clk);
            check("rx_stop_bit", out, 1'b1);
            check("rx_data", mon_d, mon_e.data);
         end
      end
   end

   // mode 0: plain; mode 1: in -> 0xFF at busy cycle 50; mode 2: txStart pulses at cycles 20 and 100
   task automatic send_frame(input logic [7:0] d, input logic p, input int mode,
                             output int nb, output int nd, output int nlow);
      @(negedge clk);
      txStart = 1'b1; in = d; parity_en = p;
      sb.push_back('{par: p, data: d});
      @(negedge clk);
      txStart = 1'b0;
      nb = 0; nd = 0; nlow = 0;
      for (int i = 0; i < 2000 && busy; i++) begin
         if (mode == 1 && nb == 50) in = 8'hFF;
         txStart = (mode == 2 && (nb == 20 || nb == 100));
         if (!out) nlow++;
         nb++;
         @(negedge clk);
      end
      txStart = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (done) nd++;
         @(negedge clk);
      end
   endtask

   int nb, nd, nlow;

   initial begin
      rst = 1'b1; txStart = 1'b1; in = 8'h3C; parity_en = 1'b0;

      // 1: reset holds the line idle even with txStart high
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_out", out, 1'b1);
         check("rst_busy", busy, 1'b0);
         check("rst_done", done, 1'b0);
      end
      rst = 1'b0;
      sb.push_back('{par: 1'b0, data: 8'h3C});
      @(negedge clk);
      check("post_rst_accept_busy", busy, 1'b1);
      check("post_rst_accept_out", out, 1'b0);
      txStart = 1'b0;
      nb = 0;
      for (int i = 0; i < 2000 && busy; i++) begin nb++; @(negedge clk); end
      check("post_rst_busy_len", nb, 160);
      check("post_rst_done", done, 1'b1);

      // 2: 0xD5 with parity
      send_frame(8'hD5, 1'b1, 0, nb, nd, nlow);
      check("d5_busy_len", nb, 176);
      check("d5_done_cnt", nd, 1);

      // 3: 0x00 without parity, input changed mid-frame
      send_frame(8'h00, 1'b0, 1, nb, nd, nlow);
      check("z_busy_len", nb, 160);
      check("z_low_cycles", nlow, 144);
      check("z_done_cnt", nd, 1);

      // 4: txStart pulses while busy are ignored
      send_frame(8'h5A, 1'b1, 2, nb, nd, nlow);
      check("ign_busy_len", nb, 176);
      check("ign_done_cnt", nd, 1);
      check("ign_idle_after", busy, 1'b0);

      // 5: back-to-back frames with txStart held through done
      @(negedge clk);
      txStart = 1'b1; in = 8'hA5; parity_en = 1'b1;
      sb.push_back('{par: 1'b1, data: 8'hA5});
      sb.push_back('{par: 1'b1, data: 8'hA5});
      @(negedge clk);
      nb = 0;
      for (int i = 0; i < 2000 && busy; i++) begin nb++; @(negedge clk); end
      check("b2b_first_len", nb, 176);
      check("b2b_done", done, 1'b1);
      check("b2b_done_out", out, 1'b1);
      @(negedge clk);
      txStart = 1'b0;
      check("b2b_second_busy", busy, 1'b1);
      check("b2b_second_start", out, 1'b0);
      check("b2b_done_one_cycle", done, 1'b0);
      nb = 0;
      for (int i = 0; i < 2000 && busy; i++) begin nb++; @(negedge clk); end
      check("b2b_second_len", nb, 176);
      repeat (4) @(negedge clk);
      check("sb_before_abort", sb.size(), 0);

      // 6: reset mid-frame aborts without a done pulse
      mon_en = 1'b0;
      txStart = 1'b1; in = 8'hC3; parity_en = 1'b1;
      @(negedge clk);
      txStart = 1'b0;
      nb = 0;
      for (int i = 0; i < 2000 && busy && nb < 50; i++) begin nb++; @(negedge clk); end
      check("abort_reached_50", nb, 50);
      rst = 1'b1;
      @(negedge clk);
      check("abort_out", out, 1'b1);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      rst = 1'b0;
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         if (done || busy) nd++;
         @(negedge clk);
      end
      check("abort_quiet", nd, 0);
      mon_en = 1'b1;
      send_frame(8'h81, 1'b0, 0, nb, nd, nlow);
      check("after_abort_len", nb, 160);
      check("after_abort_done_cnt", nd, 1);

      repeat (10) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
